// File: rtl/simplebus_pkg.sv
// Shared types for the simplebus request queue: request record, queue FSM
// states, default bus widths and a saturating counter helper.
// Ports: none (package).
package simplebus_pkg;

  localparam int SB_AW = 16;
  localparam int SB_DW = 8;

  typedef struct packed {
    logic             write;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] wdata;
  } sb_req_t;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_ISSUE,
    Q_WAIT
  } sbq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sb_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sbq_fifo.sv
// Request FIFO for the simplebus queue: DEPTH entries of sb_req_t.
// Ports: clock/reset (sync, active-high); push/push_dat write at the tail,
//   pop retires the head; head_dat, full, empty, count reflect registered state.
module sbq_fifo
  import simplebus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  sb_req_t                  push_dat,
  input  logic                     pop,
  output sb_req_t                  head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  sb_req_t         mem_q [DEPTH];
  sb_req_t         mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full     = (count_q == DEPTH[PW:0]);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Guard locally so a caller can never overflow or underflow the storage.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of 2: wraps naturally
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/simplebus_req_queue.sv
// Request queue in front of the simplebus leader: buffers core read/write
// requests, issues them one at a time, and returns read data with its address.
// Ports: clock/reset (sync, active-high); req_* core push side (valid/ready);
//   cmd_* leader command (valid/ready) plus cmd_done/cmd_rdata completion;
//   rd_* one-cycle read response; busy. Optional build macro
//   SIMPLEBUS_REQ_STATS_EN adds wr_issued, rd_issued, stall_cycles counters.
module simplebus_req_queue
  import simplebus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,  // must equal SB_AW (sb_req_t layout)
  parameter int DW    = SB_DW   // must equal SB_DW (sb_req_t layout)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_write,
  output logic [AW-1:0] cmd_addr,
  output logic [DW-1:0] cmd_wdata,
  input  logic          cmd_done,
  input  logic [DW-1:0] cmd_rdata,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy
`ifdef SIMPLEBUS_REQ_STATS_EN
  ,
  output logic [15:0]   wr_issued,
  output logic [15:0]   rd_issued,
  output logic [15:0]   stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  sb_req_t        req_dat;
  sb_req_t        head;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           push, pop;

  sbq_state_t     state_q, state_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic           out_write_q, out_write_d;
  logic [AW-1:0]  out_addr_q, out_addr_d;
  logic           rd_valid_q, rd_valid_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;

  assign req_dat = {req_write, req_addr, req_wdata};

  // Ready comes from the registered count only, so a pop in the same cycle
  // never lets a push into a full queue.
  assign req_ready = !reset && !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == Q_ISSUE) && cmd_ready;

  sbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (req_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The head entry only moves on a pop, and a pop only happens on the
  // handshake, so the command fields are stable while cmd_valid is high.
  assign cmd_valid = cmd_valid_q;
  assign cmd_write = head.write;
  assign cmd_addr  = head.addr;
  assign cmd_wdata = head.wdata;

  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign busy      = (fifo_count != '0) || (state_q != Q_IDLE);

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    out_write_d = out_write_q;
    out_addr_d  = out_addr_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      Q_IDLE: begin
        if (!fifo_empty) begin
          state_d     = Q_ISSUE;
          cmd_valid_d = 1'b1;
        end
      end
      Q_ISSUE: begin
        if (cmd_ready) begin
          out_write_d = head.write;
          out_addr_d  = head.addr;
          state_d     = Q_WAIT;
          cmd_valid_d = 1'b0;
        end
      end
      Q_WAIT: begin
        if (cmd_done) begin
          if (!out_write_q) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = out_addr_q;
            rd_data_d  = cmd_rdata;
          end
          if (!fifo_empty) begin
            state_d     = Q_ISSUE;
            cmd_valid_d = 1'b1;
          end else begin
            state_d = Q_IDLE;
          end
        end
      end
      default: begin
        state_d     = Q_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= Q_IDLE;
      cmd_valid_q <= 1'b0;
      out_write_q <= 1'b0;
      out_addr_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      out_write_q <= out_write_d;
      out_addr_q  <= out_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

`ifdef SIMPLEBUS_REQ_STATS_EN
  logic [15:0] wr_issued_q, wr_issued_d;
  logic [15:0] rd_issued_q, rd_issued_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    wr_issued_d    = wr_issued_q;
    rd_issued_d    = rd_issued_q;
    stall_cycles_d = stall_cycles_q;
    if (pop && head.write)      wr_issued_d    = sb_sat_inc(wr_issued_q);
    if (pop && !head.write)     rd_issued_d    = sb_sat_inc(rd_issued_q);
    if (req_valid && !req_ready) stall_cycles_d = sb_sat_inc(stall_cycles_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_issued_q    <= '0;
      rd_issued_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      wr_issued_q    <= wr_issued_d;
      rd_issued_q    <= rd_issued_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign wr_issued    = wr_issued_q;
  assign rd_issued    = rd_issued_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_simplebus_req_queue.sv
// Bench for simplebus_req_queue: directed request sequences against a
// behavioural leader (byte memory, programmable completion latency).
module tb_simplebus_req_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata, cmd_rdata;
  logic        cmd_done;
  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        busy;
`ifdef SIMPLEBUS_REQ_STATS_EN
  logic [15:0] wr_issued, rd_issued, stall_cycles;
`endif

  always #5 clock = ~clock;

  simplebus_req_queue dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_done  (cmd_done),
    .cmd_rdata (cmd_rdata),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
`ifdef SIMPLEBUS_REQ_STATS_EN
    ,
    .wr_issued    (wr_issued),
    .rd_issued    (rd_issued),
    .stall_cycles (stall_cycles)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Leader model state and observation queues.
  bit          leader_en = 1'b0;
  int          lat = 2;
  logic [7:0]  mem [0:65535];
  logic [24:0] issued_q[$];   // {write, addr, wdata} per handshake
  logic [23:0] rd_q[$];       // {addr, data} per rd_valid cycle

  task automatic leader();
    bit          pending = 1'b0;
    bit          hs = 1'b0;
    int          cnt = 0;
    logic        hw = 1'b0, ow = 1'b0;
    logic [15:0] ha = '0, oa = '0;
    logic [7:0]  hd = '0, od = '0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    cmd_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (hs) begin
        pending = 1'b1;
        cnt = lat;
        ow = hw; oa = ha; od = hd;
        issued_q.push_back({hw, ha, hd});
      end
      cmd_done = 1'b0;
      if (pending) begin
        if (cnt <= 1) begin
          cmd_done  = 1'b1;
          cmd_rdata = ow ? 8'h00 : mem[oa];
          if (ow) mem[oa] = od;
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
      cmd_ready = leader_en && !pending && !cmd_done;
      hs = cmd_valid && cmd_ready;
      hw = cmd_write; ha = cmd_addr; hd = cmd_wdata;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (rd_valid === 1'b1) rd_q.push_back({rd_addr, rd_data});
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d, output int stalls);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    stalls = 0;
    while (req_ready !== 1'b1 && stalls < 500) begin
      @(negedge clock);
      stalls++;
    end
    if (stalls >= 500) check("push_timeout", 32'(stalls), 32'd0);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(n), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  function automatic logic [24:0] iss(input int i);
    return (issued_q.size() > i) ? issued_q[i] : 25'hx;
  endfunction

  function automatic logic [23:0] rdr(input int i);
    return (rd_q.size() > i) ? rd_q[i] : 24'hx;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    fork
      leader();
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_rd_valid",  rd_valid,  0);
    check("rst_busy",      busy,      0);
    check("rst_rd_addr",   rd_addr,   0);
    check("rst_rd_data",   rd_data,   0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", req_ready, 1);

    // 1: single write
    leader_en = 1'b1;
    lat = 2;
    push(1'b1, 16'h0406, 8'hDC, s);
    check("t1_valid_early", cmd_valid, 0);
    @(negedge clock);
    check("t1_cmd_valid", cmd_valid, 1);
    check("t1_cmd_write", cmd_write, 1);
    check("t1_cmd_addr",  cmd_addr,  16'h0406);
    check("t1_cmd_wdata", cmd_wdata, 8'hDC);
    wait_idle();
    check("t1_busy",     busy, 0);
    check("t1_n_issued", issued_q.size(), 1);
    check("t1_issued0",  iss(0), {1'b1, 16'h0406, 8'hDC});
    check("t1_no_rd",    rd_q.size(), 0);

    // 2: read back with 5-cycle leader latency
    issued_q.delete();
    lat = 5;
    push(1'b0, 16'h0406, 8'h00, s);
    wait_idle();
    check("t2_n_rd", rd_q.size(), 1);
    check("t2_rd0",  rdr(0), {16'h0406, 8'hDC});

    // 3: fill to DEPTH with leader stalled, 5th request blocked
    do_reset();
    issued_q.delete();
    rd_q.delete();
    leader_en = 1'b0;
    lat = 2;
    push(1'b1, 16'h0407, 8'hAB, s);
    push(1'b0, 16'h0406, 8'h00, s);
    push(1'b0, 16'h0407, 8'h00, s);
    push(1'b1, 16'h0000, 8'h11, s);
    check("t3_full_ready", req_ready, 0);
    check("t3_hold_valid", cmd_valid, 1);
    check("t3_hold_addr",  cmd_addr,  16'h0407);
    fork
      push(1'b1, 16'h0001, 8'h22, s);
      begin
        repeat (6) @(posedge clock);
        #1 leader_en = 1'b1;
      end
    join
    check("t3_stalls", 32'(s), 32'd7);
    wait_idle();
    check("t3_n_issued", issued_q.size(), 5);
    check("t3_iss0", iss(0), {1'b1, 16'h0407, 8'hAB});
    check("t3_iss1", iss(1), {1'b0, 16'h0406, 8'h00});
    check("t3_iss2", iss(2), {1'b0, 16'h0407, 8'h00});
    check("t3_iss3", iss(3), {1'b1, 16'h0000, 8'h11});
    check("t3_iss4", iss(4), {1'b1, 16'h0001, 8'h22});
    check("t3_n_rd", rd_q.size(), 2);
    check("t3_rd0",  rdr(0), {16'h0406, 8'hDC});
    check("t3_rd1",  rdr(1), {16'h0407, 8'hAB});
`ifdef SIMPLEBUS_REQ_STATS_EN
    check("st_wr_issued",    wr_issued,    3);
    check("st_rd_issued",    rd_issued,    2);
    check("st_stall_cycles", stall_cycles, 7);
`endif

    // 4: push and pop on the same edge with two entries queued
    issued_q.delete();
    rd_q.delete();
    leader_en = 1'b0;
    push(1'b0, 16'h0407, 8'h00, s);
    push(1'b1, 16'h0010, 8'h55, s);
    @(posedge clock);
    #1 leader_en = 1'b1;
    @(negedge clock);
    push(1'b0, 16'h0010, 8'h00, s);
    check("t4_no_stall",  32'(s), 32'd0);
    check("t4_cmd_valid", cmd_valid, 0);
    wait_idle();
    check("t4_n_issued", issued_q.size(), 3);
    check("t4_iss0", iss(0), {1'b0, 16'h0407, 8'h00});
    check("t4_iss1", iss(1), {1'b1, 16'h0010, 8'h55});
    check("t4_iss2", iss(2), {1'b0, 16'h0010, 8'h00});
    check("t4_n_rd", rd_q.size(), 2);
    check("t4_rd0",  rdr(0), {16'h0407, 8'hAB});
    check("t4_rd1",  rdr(1), {16'h0010, 8'h55});

    // 5: reset while a read is outstanding and two requests are queued
    issued_q.delete();
    rd_q.delete();
    leader_en = 1'b0;
    push(1'b0, 16'h0407, 8'h00, s);
    push(1'b1, 16'h0020, 8'h66, s);
    push(1'b0, 16'h0020, 8'h00, s);
    lat = 8;
    @(posedge clock);
    #1 leader_en = 1'b1;
    n = 0;
    while (issued_q.size() == 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("t5_issue_timeout", 32'(n), 32'd0);
    leader_en = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_cmd_valid", cmd_valid, 0);
    check("t5_rst_busy",      busy,      0);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check("t5_busy",      busy,      0);
    check("t5_cmd_valid", cmd_valid, 0);
    check("t5_n_issued",  issued_q.size(), 1);
    check("t5_no_rd",     rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
